ball_move_gate: RTL and testbench

Collision gate between the ball position counter and the maze map ROM. It takes a proposed ball cell (x, y) and reads the target cells from the map ROM one axis at a time: X first, then Y from the newly committed X. It commits each axis only if its cell is open and in bounds, which lets the ball slide along walls. Its committed x_out/y_out drive the VGA sprite renderer and the game-logic block.

---
 rtl/ball_map_pkg.sv | 26 ++
 rtl/ball_move_gate_lat_counter.sv | 33 +++
 rtl/ball_move_gate.sv | 162 ++++++++++++++++
 tb/tb_ball_move_gate.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ball_map_pkg.sv
// Shared maze-map definitions: cell codes, gate FSM states and map address helpers.
// Imported by the move gate, the ROM controller and the sprite renderer.
package ball_map_pkg;

  localparam logic [1:0] CELL_OPEN = 2'd0;
  localparam logic [1:0] CELL_GOAL = 2'd1;
  localparam logic [1:0] CELL_WALL = 2'd2;

  typedef enum logic [1:0] {IDLE, CHK_X, CHK_Y, DONE} state_e;

  // How one axis of a proposed move is resolved.
  typedef enum logic [1:0] {AX_SKIP, AX_OOB, AX_READ} axis_e;

  function automatic logic [15:0] cell_addr(input logic [7:0] x, input logic [7:0] y,
                                            input int unsigned map_w);
    return 16'(32'(y) * map_w + 32'(x));
  endfunction

  function automatic axis_e axis_mode(input logic [7:0] req, input logic [7:0] cur,
                                      input int unsigned bound);
    if (req == cur) return AX_SKIP;
    if (32'(req) >= bound) return AX_OOB;
    return AX_READ;
  endfunction

endpackage

// File: rtl/ball_move_gate_lat_counter.sv
// Down-counter loaded with ROM_LATENCY-1 at the start of each axis check;
// done_o marks the cycle in which map_data belongs to the presented address.
module lat_counter #(
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic done_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 3'(ROM_LATENCY - 1);
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 3'd0);

endmodule

// File: rtl/ball_move_gate.sv
// Collision gate: resolves a proposed ball cell one axis at a time against the map ROM,
// X first, then Y from the freshly committed X, so the ball can slide along walls.
module ball_move_gate
  import ball_map_pkg::*;
#(
  parameter int unsigned MAP_W       = 16,
  parameter int unsigned MAP_H       = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned CELL_W      = 2,
  parameter int unsigned WALL_CODE   = 32'(CELL_WALL),
  parameter int unsigned START_X     = 1,
  parameter int unsigned START_Y     = 1,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [7:0]        req_x,
  input  logic [7:0]        req_y,
  output logic              busy,
  output logic              map_rd_en,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [CELL_W-1:0] map_data,
  output logic [7:0]        x_out,
  output logic [7:0]        y_out,
  output logic              move_done,
  output logic              blocked_x,
  output logic              blocked_y
);

  localparam logic [CELL_W-1:0] WALL_C = CELL_W'(WALL_CODE);

  state_e            state_q, state_d;
  axis_e             x_mode_q, x_mode_d, y_mode_q, y_mode_d;
  logic [7:0]        req_x_q, req_x_d, req_y_q, req_y_d;
  logic [7:0]        x_out_q, x_out_d, y_out_q, y_out_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              move_done_q, move_done_d;
  logic              blk_x_q, blk_x_d, blk_y_q, blk_y_d;
  logic              blk_x_pend_q, blk_x_pend_d;
  logic              lat_load, lat_done, wall_hit;

  lat_counter #(.ROM_LATENCY(ROM_LATENCY)) u_lat (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (lat_load),
    .done_o (lat_done)
  );

  always_comb begin
    state_d      = state_q;
    x_mode_d     = x_mode_q;
    y_mode_d     = y_mode_q;
    req_x_d      = req_x_q;
    req_y_d      = req_y_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    busy_d       = busy_q;
    rd_en_d      = 1'b0;
    addr_d       = addr_q;
    move_done_d  = 1'b0;
    blk_x_d      = blk_x_q;
    blk_y_d      = blk_y_q;
    blk_x_pend_d = blk_x_pend_q;
    lat_load     = 1'b0;
    wall_hit     = (map_data == WALL_C);

    case (state_q)
      // DONE accepts a request too, giving one request per 2*ROM_LATENCY+1 cycles.
      IDLE, DONE: begin
        state_d = IDLE;
        if (req_valid) begin
          req_x_d  = req_x;
          req_y_d  = req_y;
          busy_d   = 1'b1;
          lat_load = 1'b1;
          state_d  = CHK_X;
          x_mode_d = axis_mode(req_x, x_out_q, MAP_W);
          if (x_mode_d == AX_READ) begin
            rd_en_d = 1'b1;
            addr_d  = ADDR_W'(cell_addr(req_x, y_out_q, MAP_W));
          end
        end
      end
      CHK_X: begin
        if (lat_done) begin
          blk_x_pend_d = (x_mode_q == AX_OOB) || ((x_mode_q == AX_READ) && wall_hit);
          if ((x_mode_q == AX_READ) && !wall_hit) begin
            x_out_d = req_x_q;
          end
          y_mode_d = axis_mode(req_y_q, y_out_q, MAP_H);
          lat_load = 1'b1;
          state_d  = CHK_Y;
          // The Y probe uses the X just committed on this edge.
          if (y_mode_d == AX_READ) begin
            rd_en_d = 1'b1;
            addr_d  = ADDR_W'(cell_addr(x_out_d, req_y_q, MAP_W));
          end
        end
      end
      CHK_Y: begin
        if (lat_done) begin
          blk_y_d = (y_mode_q == AX_OOB) || ((y_mode_q == AX_READ) && wall_hit);
          if ((y_mode_q == AX_READ) && !wall_hit) begin
            y_out_d = req_y_q;
          end
          blk_x_d     = blk_x_pend_q;
          move_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_mode_q     <= AX_SKIP;
      y_mode_q     <= AX_SKIP;
      req_x_q      <= 8'd0;
      req_y_q      <= 8'd0;
      x_out_q      <= 8'(START_X);
      y_out_q      <= 8'(START_Y);
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      move_done_q  <= 1'b0;
      blk_x_q      <= 1'b0;
      blk_y_q      <= 1'b0;
      blk_x_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_mode_q     <= x_mode_d;
      y_mode_q     <= y_mode_d;
      req_x_q      <= req_x_d;
      req_y_q      <= req_y_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      move_done_q  <= move_done_d;
      blk_x_q      <= blk_x_d;
      blk_y_q      <= blk_y_d;
      blk_x_pend_q <= blk_x_pend_d;
    end
  end

  assign busy      = busy_q;
  assign map_rd_en = rd_en_q;
  assign map_addr  = addr_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign move_done = move_done_q;
  assign blocked_x = blk_x_q;
  assign blocked_y = blk_y_q;

endmodule

// File: tb/tb_ball_move_gate.sv
// Directed bench for ball_move_gate: a latency-1 and a latency-3 instance share one map,
// expected reads and results are queued at issue time and checked when the DUT produces them.
module tb_ball_move_gate;

  typedef struct { logic [7:0] x; logic [7:0] y; logic bx; logic by; int cyc; } res_t;
  typedef struct { int addr; int cyc; } rd_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_valid3;
  logic [7:0] req_x, req_y;

  logic       busy, map_rd_en, move_done, blocked_x, blocked_y;
  logic [7:0] map_addr, x_out, y_out;
  logic [1:0] map_data;
  logic       busy3, map_rd_en3, move_done3, blocked_x3, blocked_y3;
  logic [7:0] map_addr3, x_out3, y_out3;
  logic [1:0] map_data3;

  logic [1:0] rom [256];
  logic [7:0] a3_p1, a3_p2;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  res_t res_q[$];
  res_t res3_q[$];
  rd_t  rd_q[$];
  rd_t  rd3_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Map model: combinational for latency 1, two extra address stages for latency 3.
  always @(posedge clk) begin
    a3_p1 <= map_addr3;
    a3_p2 <= a3_p1;
  end
  assign map_data  = rom[map_addr];
  assign map_data3 = rom[a3_p2];

  ball_move_gate #(.ROM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .busy(busy), .map_rd_en(map_rd_en), .map_addr(map_addr), .map_data(map_data),
    .x_out(x_out), .y_out(y_out), .move_done(move_done),
    .blocked_x(blocked_x), .blocked_y(blocked_y)
  );

  ball_move_gate #(.ROM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_x(req_x), .req_y(req_y),
    .busy(busy3), .map_rd_en(map_rd_en3), .map_addr(map_addr3), .map_data(map_data3),
    .x_out(x_out3), .y_out(y_out3), .move_done(move_done3),
    .blocked_x(blocked_x3), .blocked_y(blocked_y3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    res_t r;
    rd_t  d;
    forever begin
      @(negedge clk);
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        d = rd_q.pop_front();
        chk("l1_rd_en", 32'(map_rd_en), 32'd1);
        chk("l1_rd_addr", 32'(map_addr), 32'(d.addr));
      end else begin
        chk("l1_rd_en_idle", 32'(map_rd_en), 32'd0);
      end
      if (res_q.size() > 0 && res_q[0].cyc == cyc) begin
        r = res_q.pop_front();
        chk("l1_move_done", 32'(move_done), 32'd1);
        chk("l1_x_out", 32'(x_out), 32'(r.x));
        chk("l1_y_out", 32'(y_out), 32'(r.y));
        chk("l1_blocked_x", 32'(blocked_x), 32'(r.bx));
        chk("l1_blocked_y", 32'(blocked_y), 32'(r.by));
        $display("txn L1 cyc=%0d pos=(%0d,%0d) bx=%0d by=%0d", cyc, x_out, y_out, blocked_x, blocked_y);
      end else begin
        chk("l1_move_done_idle", 32'(move_done), 32'd0);
      end
      if (rd3_q.size() > 0 && rd3_q[0].cyc == cyc) begin
        d = rd3_q.pop_front();
        chk("l3_rd_en", 32'(map_rd_en3), 32'd1);
        chk("l3_rd_addr", 32'(map_addr3), 32'(d.addr));
      end else begin
        chk("l3_rd_en_idle", 32'(map_rd_en3), 32'd0);
      end
      if (res3_q.size() > 0 && res3_q[0].cyc == cyc) begin
        r = res3_q.pop_front();
        chk("l3_move_done", 32'(move_done3), 32'd1);
        chk("l3_x_out", 32'(x_out3), 32'(r.x));
        chk("l3_y_out", 32'(y_out3), 32'(r.y));
        chk("l3_blocked_x", 32'(blocked_x3), 32'(r.bx));
        chk("l3_blocked_y", 32'(blocked_y3), 32'(r.by));
        $display("txn L3 cyc=%0d pos=(%0d,%0d) bx=%0d by=%0d", cyc, x_out3, y_out3, blocked_x3, blocked_y3);
      end else begin
        chk("l3_move_done_idle", 32'(move_done3), 32'd0);
      end
    end
  endtask

  // Drive one request and queue its expected reads (-1 = none) and result.
  task automatic issue(input bit l3, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] ex, input logic [7:0] ey, input logic ebx,
                       input logic eby, input int xaddr, input int yaddr);
    int   lat, c;
    res_t r;
    rd_t  d;
    @(negedge clk);
    lat = l3 ? 3 : 1;
    c   = cyc;
    r   = '{x: ex, y: ey, bx: ebx, by: eby, cyc: c + 1 + 2 * lat};
    if (l3) res3_q.push_back(r); else res_q.push_back(r);
    if (xaddr >= 0) begin
      d = '{addr: xaddr, cyc: c + 1};
      if (l3) rd3_q.push_back(d); else rd_q.push_back(d);
    end
    if (yaddr >= 0) begin
      d = '{addr: yaddr, cyc: c + 1 + lat};
      if (l3) rd3_q.push_back(d); else rd_q.push_back(d);
    end
    req_x = x;
    req_y = y;
    if (l3) req_valid3 = 1'b1; else req_valid = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (res_q.size() + res3_q.size() + rd_q.size() + rd3_q.size()) > 0; i++)
      @(negedge clk);
    chk("drain_results", 32'(res_q.size() + res3_q.size()), 32'd0);
    chk("drain_reads", 32'(rd_q.size() + rd3_q.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"}, 32'(x_out), 32'd1);
    chk({tag, "_y"}, 32'(y_out), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rd_en"}, 32'(map_rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(map_addr), 32'd0);
    chk({tag, "_done"}, 32'(move_done), 32'd0);
    chk({tag, "_bx"}, 32'(blocked_x), 32'd0);
    chk({tag, "_by"}, 32'(blocked_y), 32'd0);
    chk({tag, "_x3"}, 32'(x_out3), 32'd1);
    chk({tag, "_y3"}, 32'(y_out3), 32'd1);
    chk({tag, "_busy3"}, 32'(busy3), 32'd0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0; req_x = 8'd0; req_y = 8'd0;
    for (int i = 0; i < 256; i++) rom[i] = 2'd0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);

    // All open: X move only, Y axis skipped.
    issue(1'b0, 8'd2, 8'd1, 8'd2, 8'd1, 1'b0, 1'b0, 18, -1);
    drain();

    // Wall at (3,1): X blocked, Y slides from x=2.
    rom[19] = 2'd2;
    issue(1'b0, 8'd3, 8'd2, 8'd2, 8'd2, 1'b1, 1'b0, 19, 34);
    drain();

    // Reach the east edge, then probe past both borders and a Y wall.
    issue(1'b0, 8'd15, 8'd1, 8'd15, 8'd1, 1'b0, 1'b0, 47, 31);
    drain();
    issue(1'b0, 8'd16, 8'd1, 8'd15, 8'd1, 1'b1, 1'b0, -1, -1);
    drain();
    issue(1'b0, 8'd15, 8'd16, 8'd15, 8'd1, 1'b0, 1'b1, -1, -1);
    drain();
    rom[15] = 2'd2;
    issue(1'b0, 8'd15, 8'd0, 8'd15, 8'd1, 1'b0, 1'b1, -1, 15);
    drain();
    repeat (3) @(negedge clk);
    chk("blocked_y_held", 32'(blocked_y), 32'd1);

    // Latency 3: per-edge commit timing (k = edges after acceptance).
    issue(1'b1, 8'd2, 8'd2, 8'd2, 8'd2, 1'b0, 1'b0, 18, 34);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("l3_x_timing", 32'(x_out3), (k >= 3) ? 32'd2 : 32'd1);
      chk("l3_y_timing", 32'(y_out3), (k >= 6) ? 32'd2 : 32'd1);
      chk("l3_busy_timing", 32'(busy3), (k >= 6) ? 32'd0 : 32'd1);
    end
    drain();

    // Second pulse while busy must be dropped.
    issue(1'b0, 8'd14, 8'd1, 8'd14, 8'd1, 1'b0, 1'b0, 30, -1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    req_x = 8'd13; req_y = 8'd2; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("dropped_req_x", 32'(x_out), 32'd14);

    // Back-to-back: the next request lands on the edge after the move_done cycle.
    issue(1'b0, 8'd13, 8'd1, 8'd13, 8'd1, 1'b0, 1'b0, 29, -1);
    @(negedge clk);
    issue(1'b0, 8'd12, 8'd1, 8'd12, 8'd1, 1'b0, 1'b0, 28, -1);
    drain();

    // Reset one edge into a request: immediate return to start, no move_done later.
    issue(1'b0, 8'd11, 8'd3, 8'd11, 8'd3, 1'b0, 1'b0, 27, 59);
    @(posedge clk);
    #1;
    reset = 1'b0;
    res_q.delete();
    rd_q.delete();
    #1;
    chk_reset_state("async_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_x", 32'(x_out), 32'd1);
    chk("post_reset_y", 32'(y_out), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
